// File: rtl/m_store_buffer_pkg.sv
// Shared store/load op encodings for the M-stage memory path.
// Store codes feed m_se_align; load codes are used by the M-stage load extender.
package m_store_buffer_pkg;

   typedef enum logic [2:0] {
      SE_NONE = 3'd0,
      SE_SW   = 3'd1,
      SE_SH   = 3'd2,
      SE_SB   = 3'd3
   } se_op_e;

   typedef enum logic [2:0] {
      DE_NONE = 3'd0,
      DE_LW   = 3'd1,
      DE_LH   = 3'd2,
      DE_LHU  = 3'd3,
      DE_LB   = 3'd4,
      DE_LBU  = 3'd5
   } de_op_e;

   localparam int WORD_BYTES = 4;
   localparam int DATA_W     = 32;

endpackage

// File: rtl/m_store_buffer_se_align.sv
// m_se_align: byte-enable and lane-replicated data generation for one store.
// With STORE_ALIGN_CHECK_EN defined, misaligned SW/SH are flagged; otherwise misaligned_o is 0.
module m_se_align
   import m_store_buffer_pkg::*;
(
   input  logic [1:0]        addr_i,
   input  logic [2:0]        seOp_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [3:0]        be_o,
   output logic [DATA_W-1:0] data_o,
   output logic              validOp_o,
   output logic              misaligned_o
);

   // Undefined op codes fall through to the default and are never pushed.
   always_comb begin
      be_o         = 4'b0000;
      data_o       = '0;
      validOp_o    = 1'b0;
      misaligned_o = 1'b0;
      case (seOp_i)
         SE_SW: begin
            be_o      = 4'b1111;
            data_o    = wdata_i;
            validOp_o = 1'b1;
`ifdef STORE_ALIGN_CHECK_EN
            misaligned_o = (addr_i != 2'b00);
`endif
         end
         SE_SH: begin
            be_o      = addr_i[1] ? 4'b1100 : 4'b0011;
            data_o    = {2{wdata_i[15:0]}};
            validOp_o = 1'b1;
`ifdef STORE_ALIGN_CHECK_EN
            misaligned_o = addr_i[0];
`endif
         end
         SE_SB: begin
            be_o      = 4'b0001 << addr_i;
            data_o    = {4{wdata_i[7:0]}};
            validOp_o = 1'b1;
         end
         default: begin
            validOp_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/m_store_buffer.sv
// m_store_buffer: small FIFO of pending stores drained to data memory over req/ack.
// Optional STORE_ALIGN_CHECK_EN rejects misaligned SW/SH and pulses st_misalign.
module m_store_buffer
   import m_store_buffer_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = 32
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          st_valid,
   output logic          st_ready,
   input  logic [AW-1:0] st_addr,
   input  logic [31:0]   st_wdata,
   input  logic [2:0]    SEOp,
   output logic          mem_req,
   input  logic          mem_ack,
   output logic [AW-1:0] mem_addr,
   output logic [3:0]    mem_be,
   output logic [31:0]   mem_wdata,
   input  logic [AW-1:0] ld_addr,
   output logic          ld_hit,
   output logic          busy,
   output logic          st_misalign
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [PW-1:0]  wrPtr_q, wrPtr_d;
   logic [PW-1:0]  rdPtr_q, rdPtr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d;

   logic [AW-3:0]  addrMem_q [DEPTH];
   logic [3:0]     beMem_q   [DEPTH];
   logic [31:0]    dataMem_q [DEPTH];

   logic [3:0]     laneBe;
   logic [31:0]    laneData;
   logic           validOp;
   logic           misaligned;
   logic           push;
   logic           pop;
   logic [1:0]     unusedLdOffset;

   m_se_align u_se_align (
      .addr_i       (st_addr[1:0]),
      .seOp_i       (SEOp),
      .wdata_i      (st_wdata),
      .be_o         (laneBe),
      .data_o       (laneData),
      .validOp_o    (validOp),
      .misaligned_o (misaligned)
   );

   assign st_ready = (count_q != FULL_COUNT);
   assign mem_req  = (count_q != '0);
   assign busy     = mem_req;
   assign push     = st_valid && st_ready && validOp && !misaligned;
   assign pop      = mem_req && mem_ack;

   assign mem_addr  = {addrMem_q[rdPtr_q], 2'b00};
   assign mem_be    = beMem_q[rdPtr_q];
   assign mem_wdata = dataMem_q[rdPtr_q];

   assign unusedLdOffset = ld_addr[1:0];

   // Pointer, occupancy and per-entry valid next state; push and pop never hit
   // the same slot because push needs a free entry and pop needs an occupied one.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      valid_d = valid_q;
      if (push) begin
         wrPtr_d          = wrPtr_q + 1'b1;
         valid_d[wrPtr_q] = 1'b1;
      end
      if (pop) begin
         rdPtr_d          = rdPtr_q + 1'b1;
         valid_d[rdPtr_q] = 1'b0;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Entry storage is cleared on reset so the head outputs read as zero when empty after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            addrMem_q[i] <= '0;
            beMem_q[i]   <= '0;
            dataMem_q[i] <= '0;
         end
      end else if (push) begin
         addrMem_q[wrPtr_q] <= st_addr[AW-1:2];
         beMem_q[wrPtr_q]   <= laneBe;
         dataMem_q[wrPtr_q] <= laneData;
      end
   end

   always_comb begin
      ld_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (addrMem_q[i] == ld_addr[AW-1:2])) begin
            ld_hit = 1'b1;
         end
      end
   end

`ifdef STORE_ALIGN_CHECK_EN
   logic misalign_q;

   // One-cycle pulse following any misaligned store attempt, accepted or not.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= st_valid && validOp && misaligned;
      end
   end

   assign st_misalign = misalign_q;
`else
   assign st_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_m_store_buffer.sv
// Directed self-checking bench for m_store_buffer (default depth 2, 32-bit address).
// Expected values are hand-computed from the store lane rules and FIFO ordering.
module tb_m_store_buffer;

   logic        clk;
   logic        reset;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_wdata;
   logic [2:0]  SEOp;
   logic        mem_req;
   logic        mem_ack;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] ld_addr;
   logic        ld_hit;
   logic        busy;
   logic        st_misalign;

   int checks;
   int failures;

   m_store_buffer #(.DEPTH(2), .AW(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .st_valid    (st_valid),
      .st_ready    (st_ready),
      .st_addr     (st_addr),
      .st_wdata    (st_wdata),
      .SEOp        (SEOp),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .mem_addr    (mem_addr),
      .mem_be      (mem_be),
      .mem_wdata   (mem_wdata),
      .ld_addr     (ld_addr),
      .ld_hit      (ld_hit),
      .busy        (busy),
      .st_misalign (st_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] d, input logic ack);
      st_valid = v;
      SEOp     = op;
      st_addr  = a;
      st_wdata = d;
      mem_ack  = ack;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      ld_addr  = 32'h0;
      applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
      #1;
      checkOutput("rst_mem_req",   {31'd0, mem_req},     32'd0);
      checkOutput("rst_busy",      {31'd0, busy},        32'd0);
      checkOutput("rst_st_ready",  {31'd0, st_ready},    32'd1);
      checkOutput("rst_ld_hit",    {31'd0, ld_hit},      32'd0);
      checkOutput("rst_mem_addr",  mem_addr,             32'd0);
      checkOutput("rst_mem_be",    {28'd0, mem_be},      32'd0);
      checkOutput("rst_mem_wdata", mem_wdata,            32'd0);
      checkOutput("rst_misalign",  {31'd0, st_misalign}, 32'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      $display("[TB] SB store with ack held high");
      applyStimulus(1'b1, 3'd3, 32'h0000_1003, 32'h0000_00AB, 1'b1);
      #1;
      checkOutput("sb_no_bypass", {31'd0, mem_req}, 32'd0);
      tick();
      applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      checkOutput("sb_mem_req",   {31'd0, mem_req}, 32'd1);
      checkOutput("sb_mem_addr",  mem_addr,         32'h0000_1000);
      checkOutput("sb_mem_be",    {28'd0, mem_be},  32'h8);
      checkOutput("sb_mem_wdata", mem_wdata,        32'hABAB_ABAB);
      tick();
      mem_ack = 1'b0;
      checkOutput("sb_drained", {31'd0, busy}, 32'd0);

      $display("[TB] SH store held for three cycles");
      applyStimulus(1'b1, 3'd2, 32'h0000_2002, 32'h1234_CDEF, 1'b0);
      tick();
      st_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("sh_hold_req",   {31'd0, mem_req}, 32'd1);
         checkOutput("sh_hold_addr",  mem_addr,         32'h0000_2000);
         checkOutput("sh_hold_be",    {28'd0, mem_be},  32'hC);
         checkOutput("sh_hold_wdata", mem_wdata,        32'hCDEF_CDEF);
         tick();
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput("sh_drained", {31'd0, busy}, 32'd0);

      $display("[TB] Invalid op codes are not pushed");
      applyStimulus(1'b1, 3'd0, 32'h0000_0040, 32'hFFFF_FFFF, 1'b0);
      tick();
      checkOutput("se_none_dropped", {31'd0, busy}, 32'd0);
      SEOp = 3'd7;
      tick();
      st_valid = 1'b0;
      checkOutput("se_undef_dropped", {31'd0, busy}, 32'd0);

      $display("[TB] Fill, overflow attempt, in-order retire");
      applyStimulus(1'b1, 3'd1, 32'h0000_0010, 32'h1111_1111, 1'b0);
      tick();
      applyStimulus(1'b1, 3'd1, 32'h0000_0014, 32'h2222_2222, 1'b0);
      tick();
      st_valid = 1'b0;
      checkOutput("full_st_ready", {31'd0, st_ready}, 32'd0);
      checkOutput("full_busy",     {31'd0, busy},     32'd1);
      applyStimulus(1'b1, 3'd1, 32'h0000_0018, 32'h3333_3333, 1'b0);
      tick();
      st_valid = 1'b0;
      checkOutput("full_head_addr", mem_addr, 32'h0000_0010);
      checkOutput("full_head_data", mem_wdata, 32'h1111_1111);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput("retire_next_addr", mem_addr,          32'h0000_0014);
      checkOutput("retire_next_data", mem_wdata,         32'h2222_2222);
      checkOutput("retire_st_ready",  {31'd0, st_ready}, 32'd1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput("overflow_dropped", {31'd0, busy}, 32'd0);

      $display("[TB] Push while full with pop, then push+pop at count 1");
      applyStimulus(1'b1, 3'd1, 32'h0000_0020, 32'hAAAA_0001, 1'b0);
      tick();
      applyStimulus(1'b1, 3'd1, 32'h0000_0024, 32'hAAAA_0002, 1'b0);
      tick();
      applyStimulus(1'b1, 3'd1, 32'h0000_0028, 32'hAAAA_0003, 1'b1);
      #1;
      checkOutput("full_pop_ready", {31'd0, st_ready}, 32'd0);
      tick();
      applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
      checkOutput("full_pop_head",  mem_addr,          32'h0000_0024);
      checkOutput("full_pop_count", {31'd0, st_ready}, 32'd1);
      applyStimulus(1'b1, 3'd1, 32'h0000_002C, 32'hAAAA_0004, 1'b1);
      tick();
      applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
      checkOutput("pushpop_busy",  {31'd0, busy},     32'd1);
      checkOutput("pushpop_ready", {31'd0, st_ready}, 32'd1);
      checkOutput("pushpop_addr",  mem_addr,          32'h0000_002C);
      checkOutput("pushpop_data",  mem_wdata,         32'hAAAA_0004);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput("pushpop_drained", {31'd0, busy}, 32'd0);

      $display("[TB] Load address match and reset mid-drain");
      ld_addr = 32'h0000_3004;
      applyStimulus(1'b1, 3'd1, 32'h0000_3004, 32'h5555_5555, 1'b0);
      #1;
      checkOutput("hit_not_same_cycle", {31'd0, ld_hit}, 32'd0);
      tick();
      st_valid = 1'b0;
      ld_addr  = 32'h0000_3006;
      #1;
      checkOutput("hit_same_word", {31'd0, ld_hit}, 32'd1);
      ld_addr = 32'h0000_3008;
      #1;
      checkOutput("hit_next_word", {31'd0, ld_hit}, 32'd0);
      ld_addr = 32'h0000_3004;
      mem_ack = 1'b1;
      #1;
      checkOutput("hit_while_pop", {31'd0, ld_hit}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("midrst_mem_req", {31'd0, mem_req}, 32'd0);
      checkOutput("midrst_ld_hit",  {31'd0, ld_hit},  32'd0);
      tick();
      mem_ack = 1'b0;
      reset   = 1'b0;
      tick();
      checkOutput("postrst_busy", {31'd0, busy}, 32'd0);

      $display("[TB] Misaligned SW");
      applyStimulus(1'b1, 3'd1, 32'h0000_4001, 32'h55AA_55AA, 1'b0);
      tick();
      st_valid = 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
      checkOutput("mis_not_pushed", {31'd0, busy},        32'd0);
      checkOutput("mis_pulse",      {31'd0, st_misalign}, 32'd1);
      tick();
      checkOutput("mis_pulse_end",  {31'd0, st_misalign}, 32'd0);
`else
      checkOutput("mis_addr",  mem_addr,             32'h0000_4000);
      checkOutput("mis_be",    {28'd0, mem_be},      32'hF);
      checkOutput("mis_data",  mem_wdata,            32'h55AA_55AA);
      checkOutput("mis_flag",  {31'd0, st_misalign}, 32'd0);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput("mis_drained", {31'd0, busy}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
